// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and line levels for the framed serial transmitter.
package piso_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/piso_serial_tx_bit_timer.sv
// bit_timer: counts clocks within one bit period and ticks on its last cycle.
module bit_timer #(
   parameter int BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clear,
   output logic tick
);
   localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      tick  = en && (cnt_q == CW'(BIT_CYCLES - 1));
      cnt_d = (clear || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: valid/ready parallel word in, start/LSB-first data/stop frame out on tx.
module piso_serial_tx
   import piso_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);
   localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              tx_q, tx_d, done_q, done_d, tick;
   assign din_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign tx        = tx_q;
   assign done      = done_q;
   bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q != IDLE),
      .clear(state_q == IDLE),
      .tick (tick)
   );
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE:
            if (din_valid) begin
               state_d = START;
               shift_d = din;
               idx_d   = '0;
               tx_d    = START_BIT;
            end
         START:
            if (tick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         DATA:
            if (tick) begin
               if (idx_q == IW'(DATA_W - 1)) begin
                  state_d = STOP;
                  tx_d    = STOP_BIT;
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
                  idx_d   = idx_q + 1'b1;
               end
            end
         STOP:
            if (tick) begin
               state_d = IDLE;
               tx_d    = STOP_BIT;
               done_d  = 1'b1;
            end
         default: state_d = IDLE;
      endcase
   end
   // tx resets to the idle level asynchronously so a mid-frame reset releases the line at once.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= STOP_BIT;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: scoreboard bench driving a BIT_CYCLES=4 and a BIT_CYCLES=1 transmitter.
module tb_piso_serial_tx;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din_a [2];
   logic [1:0] vld_a = '0;
   logic [1:0] rdy_a, tx_a, busy_a, done_a;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int BC = (g == 0) ? 4 : 1;
      logic [1:0] q [$];
      piso_serial_tx #(.DATA_W(8), .BIT_CYCLES(BC)) dut (
         .clk      (clk),
         .rst      (rst),
         .din      (din_a[g]),
         .din_valid(vld_a[g]),
         .din_ready(rdy_a[g]),
         .tx       (tx_a[g]),
         .busy     (busy_a[g]),
         .done     (done_a[g])
      );
      // Each entry is {done, tx} expected for one cycle; empty queue means idle line.
      always @(negedge clk) begin
         logic [1:0] e;
         logic       lvl;
         if (rst) begin
            q.delete();
            check("rst_tx", tx_a[g], 1);
            check("rst_ready", rdy_a[g], 1);
            check("rst_busy", busy_a[g], 0);
            check("rst_done", done_a[g], 0);
         end else begin
            if (q.size() != 0) begin
               e = q.pop_front();
               check("tx", tx_a[g], e[0]);
               check("done", done_a[g], e[1]);
               check("busy", busy_a[g], !e[1]);
               check("ready", rdy_a[g], e[1]);
            end else begin
               check("idle_tx", tx_a[g], 1);
               check("idle_done", done_a[g], 0);
               check("idle_busy", busy_a[g], 0);
               check("idle_ready", rdy_a[g], 1);
            end
            if (vld_a[g] && rdy_a[g]) begin
               for (int b = 0; b < 10; b++) begin
                  lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : din_a[g][b-1];
                  for (int c = 0; c < BC; c++) q.push_back({1'b0, lvl});
               end
               q.push_back(2'b11);
            end
         end
      end
   end

   task automatic send(input int g, input logic [7:0] d, input bit keep);
      int n = 0;
      @(posedge clk);
      #1;
      din_a[g] = d;
      vld_a[g] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy_a[g] && n < 200);
      if (!rdy_a[g]) check("accept_timeout", rdy_a[g], 1);
      @(posedge clk);
      #1;
      if (!keep) vld_a[g] = 1'b0;
   endtask

   initial begin
      din_a[0] = '0;
      din_a[1] = '0;
      #100;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      send(0, 8'hA5, 0);
      send(1, 8'h01, 0);
      repeat (50) @(posedge clk);
      send(0, 8'h3C, 1);
      send(0, 8'hFF, 0);
      repeat (50) @(posedge clk);
      send(0, 8'h00, 1);
      send(0, 8'hFF, 0);
      repeat (50) @(posedge clk);
      send(0, 8'h81, 0);
      repeat (17) @(posedge clk);
      #2;
      check("pre_rst_bit3", tx_a[0], 0);
      rst = 1'b1;
      #1;
      check("async_rst_tx", tx_a[0], 1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (50) @(posedge clk);
      send(0, 8'h55, 0);
      send(1, 8'h01, 0);
      repeat (50) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
